// File: rtl/line_steer_ctrl.sv
// Line-following steering controller: sensor pattern -> ramped duty words for two PWM generators.
// Optional feature: define LINE_STEER_SEARCH_EN to spin-search after the line is lost too long.
module line_steer_ctrl #(
  parameter logic [7:0]  CRUISE     = 8'hC0,
  parameter logic [7:0]  TURN       = 8'h40,
  parameter logic [7:0]  RAMP_STEP  = 8'h04,
  parameter logic [15:0] TICK_DIV   = 16'd50000,
  parameter logic [7:0]  LOST_LIMIT = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] sensor,
  output logic [7:0] left_duty,
  output logic [7:0] right_duty,
  output logic       left_en,
  output logic       right_en,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_LOST   = 3'd2,
    S_SEARCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      st, st_nxt;
  logic [15:0] pre;
  logic [7:0]  lost_cnt;
  logic [2:0]  pat;
  logic        tick;
  logic [15:0] tgt;
  logic [7:0]  l_nxt, r_nxt;

  // Move duty toward tgt by at most RAMP_STEP, landing exactly on tgt when close.
  function automatic logic [7:0] slew(input logic [7:0] duty, input logic [7:0] goal);
    if (goal > duty)
      slew = ((goal - duty) > RAMP_STEP) ? duty + RAMP_STEP : goal;
    else
      slew = ((duty - goal) > RAMP_STEP) ? duty - RAMP_STEP : goal;
  endfunction

  // Packed {left, right} targets for a non-zero sensor pattern.
  function automatic logic [15:0] pattern_targets(input logic [2:0] p);
    case (p)
      3'b100, 3'b110: pattern_targets = {TURN, CRUISE};
      3'b001, 3'b011: pattern_targets = {CRUISE, TURN};
      default:        pattern_targets = {CRUISE, CRUISE};
    endcase
  endfunction

  assign tick = (st != S_IDLE) && (pre == TICK_DIV - 16'd1);

  always_comb begin
    tgt = 16'h0000;
    case (st)
      S_RUN:    tgt = pattern_targets((sensor != 3'b000) ? sensor : pat);
      S_LOST:   tgt = pattern_targets(pat);
      S_SEARCH: tgt = pat[2] ? {8'h00, TURN} : {TURN, 8'h00};
      default:  tgt = 16'h0000;
    endcase
  end

  assign l_nxt = tick ? slew(left_duty, tgt[15:8]) : left_duty;
  assign r_nxt = tick ? slew(right_duty, tgt[7:0]) : right_duty;

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: if (start && !stop) st_nxt = S_RUN;
      S_RUN: begin
        if (stop)                   st_nxt = S_HALT;
        else if (sensor == 3'b000)  st_nxt = S_LOST;
      end
      S_LOST: begin
        if (stop)                         st_nxt = S_HALT;
        else if (sensor != 3'b000)        st_nxt = S_RUN;
        else if (lost_cnt == LOST_LIMIT) begin
`ifdef LINE_STEER_SEARCH_EN
          st_nxt = S_SEARCH;
`else
          st_nxt = S_HALT;
`endif
        end
      end
      S_SEARCH: begin
        if (stop)                   st_nxt = S_HALT;
        else if (sensor != 3'b000)  st_nxt = S_RUN;
      end
      // Leave HALT on the same edge the duties land on zero so enables drop with them.
      S_HALT: if (l_nxt == 8'h00 && r_nxt == 8'h00) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      pre        <= 16'd0;
      lost_cnt   <= 8'd0;
      pat        <= 3'b010;
      left_duty  <= 8'h00;
      right_duty <= 8'h00;
    end else begin
      st         <= st_nxt;
      pre        <= (st_nxt == S_IDLE || tick) ? 16'd0 : pre + 16'd1;
      lost_cnt   <= (st != S_LOST) ? 8'd0 : (tick ? lost_cnt + 8'd1 : lost_cnt);
      if (st == S_RUN && sensor != 3'b000)
        pat <= sensor;
      left_duty  <= l_nxt;
      right_duty <= r_nxt;
    end
  end

  assign state    = st;
  assign left_en  = (st != S_IDLE);
  assign right_en = (st != S_IDLE);

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Bench for line_steer_ctrl: directed scenarios followed by random stimulus against a behavioural model.
module tb_line_steer_ctrl;
  localparam int TDIV  = 4;
  localparam int STEP  = 4;
  localparam int CRU   = 16;
  localparam int TRN   = 8;
  localparam int LIMIT = 3;
`ifdef LINE_STEER_SEARCH_EN
  localparam int LOST_EXIT = 3;
`else
  localparam int LOST_EXIT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [2:0] sens;
  logic [7:0] left_duty, right_duty;
  logic       left_en, right_en;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int m_st, m_l, m_r, m_pre, m_lost, m_pat;

  line_steer_ctrl #(
    .CRUISE(8'h10), .TURN(8'h08), .RAMP_STEP(8'h04),
    .TICK_DIV(16'd4), .LOST_LIMIT(8'd3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sensor(sens),
    .left_duty(left_duty), .right_duty(right_duty),
    .left_en(left_en), .right_en(right_en), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int approach(input int d, input int t);
    if (d < t) return (d + STEP < t) ? d + STEP : t;
    return (d - STEP > t) ? d - STEP : t;
  endfunction

  task automatic pat_tgt(input int p, output int tl, output int tr);
    tl = CRU; tr = CRU;
    if (p == 4 || p == 6) tl = TRN;
    if (p == 1 || p == 3) tr = TRN;
  endtask

  task automatic model_reset();
    m_st = 0; m_l = 0; m_r = 0; m_pre = 0; m_lost = 0; m_pat = 2;
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic model_step();
    int tl, tr, nl, nr, ns, s;
    bit tk;
    s  = int'(sens);
    tk = (m_st != 0) && (m_pre == TDIV - 1);
    tl = 0; tr = 0;
    if (m_st == 1)      pat_tgt((s != 0) ? s : m_pat, tl, tr);
    else if (m_st == 2) pat_tgt(m_pat, tl, tr);
    else if (m_st == 3) begin
      if (m_pat >= 4) begin tl = 0; tr = TRN; end
      else begin tl = TRN; tr = 0; end
    end
    nl = tk ? approach(m_l, tl) : m_l;
    nr = tk ? approach(m_r, tr) : m_r;
    ns = m_st;
    case (m_st)
      0: if (start && !stop) ns = 1;
      1: if (stop) ns = 4; else if (s == 0) ns = 2;
      2: if (stop) ns = 4; else if (s != 0) ns = 1; else if (m_lost == LIMIT) ns = LOST_EXIT;
      3: if (stop) ns = 4; else if (s != 0) ns = 1;
      4: if (nl == 0 && nr == 0) ns = 0;
      default: ns = 0;
    endcase
    if (m_st == 1 && s != 0) m_pat = s;
    m_lost = (m_st == 2) ? m_lost + int'(tk) : 0;
    m_pre  = (ns == 0 || tk) ? 0 : m_pre + 1;
    m_st = ns; m_l = nl; m_r = nr;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("m_state", state, m_st);
    check("m_left", left_duty, m_l);
    check("m_right", right_duty, m_r);
    check("m_len", left_en, (m_st != 0));
    check("m_ren", right_en, (m_st != 0));
  endtask

  // Reset pulse between clock edges; outputs must clear before the next edge.
  task automatic areset();
    #2 rst = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_left", left_duty, 0);
    check("rst_right", right_duty, 0);
    check("rst_en", {left_en, right_en}, 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int exp_l, prev;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sens = 3'b010;
    model_reset();
    #12;
    check("reset_state", state, 0);
    check("reset_duty", {left_duty, right_duty}, 0);
    check("reset_en", {left_en, right_en}, 0);
    rst = 1'b0;

    // Ramp up on a centred line, start held high in RUN.
    start = 1'b1;
    cyc();
    check("start_run", state, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (TDIV) cyc();
      check("ramp_left", left_duty, 4 * k);
      check("ramp_right", right_duty, 4 * k);
    end
    repeat (TDIV) cyc();
    check("hold_left", left_duty, 16);
    check("start_in_run", state, 1);
    check("run_en", {left_en, right_en}, 2'b11);

    // Line drifts left: left wheel slows to TURN.
    sens = 3'b100;
    repeat (TDIV) cyc();
    check("turn1_left", left_duty, 12);
    repeat (TDIV) cyc();
    check("turn2_left", left_duty, 8);
    repeat (TDIV) cyc();
    check("turn3_left", left_duty, 8);
    check("turn_right", right_duty, 16);

    // Line lost.
    sens = 3'b000;
    cyc();
    check("lost_enter", state, 2);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (state != 3'd2) break;
    end
    check("lost_exit", state, LOST_EXIT);
    if (state == 3'd3) begin
      sens = 3'b001;
      cyc();
      check("search_found", state, 1);
    end
    stop = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (state == 3'd0) break;
      cyc();
    end
    check("lost_idle", state, 0);
    check("lost_idle_duty", {left_duty, right_duty}, 0);
    check("lost_idle_en", {left_en, right_en}, 0);
    stop = 1'b0;

    // Orderly halt with start and stop both high.
    sens = 3'b010; start = 1'b1;
    cyc();
    check("run2", state, 1);
    repeat (4 * TDIV) cyc();
    check("run2_duty", {left_duty, right_duty}, 16'h1010);
    stop = 1'b1;
    cyc();
    check("halt_enter", state, 4);
    exp_l = 12;
    for (int i = 0; i < 40; i++) begin
      prev = int'(left_duty);
      cyc();
      if (int'(left_duty) != prev) begin
        check("halt_left", left_duty, exp_l);
        check("halt_right", right_duty, exp_l);
        if (exp_l == 0) begin
          check("halt_idle", state, 0);
          check("halt_en", {left_en, right_en}, 0);
          break;
        end
        exp_l -= 4;
      end
    end
    check("halt_done", state, 0);

    // stop in IDLE does nothing.
    start = 1'b0;
    repeat (3) cyc();
    check("stop_idle", state, 0);
    check("stop_idle_duty", left_duty, 0);
    stop = 1'b0;

    // Reset mid-ramp, then start sampled on the first edge.
    start = 1'b1;
    cyc();
    repeat (2 * TDIV) cyc();
    check("mid_ramp", left_duty, 8);
    areset();
    cyc();
    check("post_rst_run", state, 1);
    start = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0)
        sens = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) start = ~start;
      stop = ($urandom_range(0, 149) == 0);
      cyc();
      if ($urandom_range(0, 799) == 0) areset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
